parking_timer: RTL
==================

# parking_timer

Time-keeping front end of the parking meter: holds remaining parking time as four BCD digits (0000–9999 seconds), adds time on coin pulses, loads fixed values on preset pulses, and counts down once per second. Encodes the four digits into active-low seven-segment patterns, with low-time and expired blinking. Sits directly upstream of the four-digit display multiplexer; its `seg0..seg3` outputs drive that block's `in0..in3`.

## Interface
- `CLK_HZ`, default 100_000_000: `clk` frequency. Must be even and ≥ 4. Half-second period = `CLK_HZ/2` cycles.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `add_60`  in  1  single-cycle pulse: add 60 s.
- `add_120`  in  1  single-cycle pulse: add 120 s.
- `add_180`  in  1  single-cycle pulse: add 180 s.
- `add_300`  in  1  single-cycle pulse: add 300 s.
- `set_10`  in  1  single-cycle pulse: load 10 s.
- `set_205`  in  1  single-cycle pulse: load 205 s.
- `seg0`  out  7  rightmost digit (ones) pattern, active-low; bit0=a … bit6=g.
- `seg1`  out  7  tens digit pattern.
- `seg2`  out  7  hundreds digit pattern.
- `seg3`  out  7  thousands digit pattern.
- `expired`  out  1  high while remaining time is 0.

All inputs are already debounced and synchronous to `clk`.

## Operation
- State: BCD digits `d3..d0`; prescaler `pcnt` (0..CLK_HZ/2-1); `half` bit (toggles every half-second); `par` bit (toggles every second).
- `htick` = (`pcnt` == CLK_HZ/2-1). `stick` = `htick` & `half`==1. On `htick`: `pcnt` wraps to 0, `half` toggles. On `stick`: `par` toggles.
- Priority per cycle: `rst` > `set_205` > `set_10` > add/decrement.
- Set: load value (0205 or 0010); `pcnt`, `half`, `par` cleared. Any simultaneous add or tick is ignored.
- Add: if several add pulses are high, only the largest takes effect (300 > 180 > 120 > 60).
- Update: new = min(value − dec + add, 9999), where dec = 1 if `stick` and value > 0, else 0. Arithmetic is BCD with carry/borrow across all four digits. Saturates at 9999 and never wraps. Decrement at 0 holds 0.
- Display select, evaluated on the post-update value:
  - value == 0: show 0000 when `half`==0, blank when `half`==1 (1 Hz flash).
  - 1..179: show digits when `par`==0, blank when `par`==1 (2 s period, 50 % duty).
  - ≥ 180: show digits steadily.
- Leading zeros are displayed, not blanked. Blank = 7'b1111111.
- Encoding (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- `expired` = (value == 0), registered.

## Timing
- Reset values: digits 0000, `pcnt` 0, `half` 0, `par` 0, `seg0..seg3` = 1000000 (shows 0000), `expired` 1.
- Pulse sampled at edge N updates the value at edge N. `seg*` and `expired` reflect the new value at edge N+1 (one registered stage). All outputs are registered.
- First decrement after a set or reset occurs CLK_HZ cycles later.
- Add pulses do not disturb the prescaler, `half`, or `par`.
- Add and `stick` in the same cycle: both are applied (e.g. 0100 + 60 − 1 = 0159).
- Reset mid-count: everything returns to reset values at that edge; pending pulses in the same cycle are ignored.
- Crossing 180→179 starts blinking with the current `par`; no phase realignment.

## Test plan
Benches use CLK_HZ = 8 (half-second = 4 cycles).
- Reset → `seg0..3` = 1000000, `expired`=1. Next 4 cycles keep 0000 shown, the following 4 cycles show blank, repeating.
- `set_205` → after 1 cycle: digits 0205, `par`=0, steady segments 1000000/0100100/1000000/0010010 (seg3..seg0) shown. After 8 cycles → 0204. After 16 → 0203.
- `set_10`, then wait 80 cycles → counts to 0000. `expired` rises, 1 Hz flash begins, value stays 0000 indefinitely.
- From 0100: `add_60` coincident with `stick` → 0159. `add_300` and `add_60` in the same cycle from 0000 → 0300 only.
- From 9950: `add_300` → 9999 (saturates). Next second → 9998.
- From 0200: wait until 0179 → segments blank during odd seconds, visible during even seconds. `set_205` and `add_60` in the same cycle → 0205, prescaler restarted.

Source files
------------

// File: rtl/parking_timer.sv
// Parking meter time base: four BCD digits of remaining seconds, coin/preset loading,
// 1 Hz countdown, and active-low seven-segment encoding with low-time/expired blinking.
module parking_timer #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add_60,
  input  logic       add_120,
  input  logic       add_180,
  input  logic       add_300,
  input  logic       set_10,
  input  logic       set_205,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic       expired
);

  localparam int HALF = CLK_HZ / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRELOAD = PW'(HALF - 1);
  localparam logic [27:0]   SEG_ZERO = {4{7'b1000000}};

  logic [15:0]   val_q, val_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          half_q, half_d;
  logic          par_q, par_d;
  logic [27:0]   seg_q, seg_d;
  logic          expired_q, expired_d;

  logic        htick, stick;
  logic [15:0] add_bcd, dec_val, sum_val, upd_val;
  logic        sum_carry;
  logic        blank;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c           = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c           = 1'b0;
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Prescaler runs as a down-counter; reaching zero marks a half-second boundary.
  always_comb begin
    htick = (pcnt_q == '0);
    stick = htick & half_q;

    if (add_300)      add_bcd = 16'h0300;
    else if (add_180) add_bcd = 16'h0180;
    else if (add_120) add_bcd = 16'h0120;
    else if (add_60)  add_bcd = 16'h0060;
    else              add_bcd = 16'h0000;

    dec_val = (stick && (val_q != 16'h0000)) ? bcd_dec(val_q) : val_q;
    {sum_carry, sum_val} = bcd_add(dec_val, add_bcd);
    upd_val = sum_carry ? 16'h9999 : sum_val;

    val_d  = upd_val;
    pcnt_d = htick ? PRELOAD : pcnt_q - PW'(1);
    half_d = half_q ^ htick;
    par_d  = par_q ^ stick;

    if (set_205) begin
      val_d  = 16'h0205;
      pcnt_d = PRELOAD;
      half_d = 1'b0;
      par_d  = 1'b0;
    end else if (set_10) begin
      val_d  = 16'h0010;
      pcnt_d = PRELOAD;
      half_d = 1'b0;
      par_d  = 1'b0;
    end
  end

  // Packed BCD preserves numeric order, so a plain compare finds the low-time band.
  always_comb begin
    if (val_q == 16'h0000)      blank = half_q;
    else if (val_q < 16'h0180)  blank = par_q;
    else                        blank = 1'b0;

    seg_d = blank ? {28{1'b1}}
                  : {enc7(val_q[15:12]), enc7(val_q[11:8]), enc7(val_q[7:4]), enc7(val_q[3:0])};
    expired_d = (val_q == 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q     <= 16'h0000;
      pcnt_q    <= PRELOAD;
      half_q    <= 1'b0;
      par_q     <= 1'b0;
      seg_q     <= SEG_ZERO;
      expired_q <= 1'b1;
    end else begin
      val_q     <= val_d;
      pcnt_q    <= pcnt_d;
      half_q    <= half_d;
      par_q     <= par_d;
      seg_q     <= seg_d;
      expired_q <= expired_d;
    end
  end

  assign seg0    = seg_q[6:0];
  assign seg1    = seg_q[13:7];
  assign seg2    = seg_q[20:14];
  assign seg3    = seg_q[27:21];
  assign expired = expired_q;

endmodule
